// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel-1 read request path.
package dma_pkg;

    // Request generator states
    typedef enum logic [2:0] {
        StIdle,
        StCalc,
        StWaitCr,
        StReq,
        StHdr
    } rd_state_e;

    localparam logic [7:0]  FMT_TYPE_MRD32 = 8'h00;
    localparam logic [7:0]  FMT_TYPE_CPLD  = 8'h4A;
    localparam logic [2:0]  CH1_TAG        = 3'b001;
    localparam int unsigned HDR_WORDS      = 6;

    // Credit counter width; INIT values must fit
    localparam int unsigned CR_W = 12;

    // Chunk size in DW: smallest of the remaining job, the max read request
    // size and the distance to the next 4 KB boundary. Never 0 because
    // remaining_dw is nonzero whenever this is used.
    function automatic logic [10:0] calc_chunk_dw(input logic [9:0]  remaining_dw,
                                                  input logic [9:0]  addr_dw_off,
                                                  input int unsigned max_rd_bytes);
        logic [10:0] to_4k;
        logic [10:0] mrrs;
        logic [10:0] chunk;
        to_4k = 11'd1024 - {1'b0, addr_dw_off};
        mrrs  = 11'(max_rd_bytes / 4);
        chunk = {1'b0, remaining_dw};
        if (mrrs < chunk) begin
            chunk = mrrs;
        end
        if (to_4k < chunk) begin
            chunk = to_4k;
        end
        return chunk;
    endfunction

endpackage

// File: rtl/dma_cr_meter.sv
// Completion header/data credit meter: two saturating counters with a
// debit port (one header + N DW) and a return port (one header + N DW).
module dma_cr_meter
    import dma_pkg::*;
#(
    parameter int unsigned CPLH_INIT = 8,
    parameter int unsigned CPLD_INIT = 128
) (
    input  logic            clk_125,
    input  logic            rst,
    input  logic            debit,
    input  logic [10:0]     debit_dw,
    input  logic            ret_h,
    input  logic [7:0]      ret_dw,
    output logic [CR_W-1:0] cplh_avail,
    output logic [CR_W-1:0] cpld_avail
);

    logic [CR_W+1:0] h_sum;
    logic [CR_W+1:0] d_sum;
    logic [CR_W+1:0] h_next;
    logic [CR_W+1:0] d_next;

    // Net of return and debit first, then clamp, so a simultaneous pair is
    // never lost to saturation.
    always_comb begin
        h_sum = {2'b00, cplh_avail};
        d_sum = {2'b00, cpld_avail};
        if (ret_h) begin
            h_sum = h_sum + (CR_W+2)'(1);
            d_sum = d_sum + (CR_W+2)'(ret_dw);
        end
        if (debit) begin
            h_sum = (h_sum >= (CR_W+2)'(1)) ? h_sum - (CR_W+2)'(1) : '0;
            d_sum = (d_sum >= (CR_W+2)'(debit_dw)) ? d_sum - (CR_W+2)'(debit_dw) : '0;
        end
        h_next = (h_sum > (CR_W+2)'(CPLH_INIT)) ? (CR_W+2)'(CPLH_INIT) : h_sum;
        d_next = (d_sum > (CR_W+2)'(CPLD_INIT)) ? (CR_W+2)'(CPLD_INIT) : d_sum;
    end

    // Counter registers, reloaded on reset
    always_ff @(posedge clk_125) begin
        if (rst) begin
            cplh_avail <= CR_W'(CPLH_INIT);
            cpld_avail <= CR_W'(CPLD_INIT);
        end else begin
            cplh_avail <= h_next[CR_W-1:0];
            cpld_avail <= d_next[CR_W-1:0];
        end
    end

endmodule

// File: rtl/dma_rd_req_tx.sv
// Channel-1 read request generator: splits a read job into MRd32 TLPs,
// meters completion credits and drives the 16-bit TX bus.
module dma_rd_req_tx
    import dma_pkg::*;
#(
    parameter int unsigned MAX_RD_BYTES = 512,
    parameter int unsigned CPLH_INIT    = 8,
    parameter int unsigned CPLD_INIT    = 128,
    parameter logic [15:0] REQ_ID       = 16'h0000
) (
    input  logic        clk_125,
    input  logic        rst,
    input  logic        ch1_start,
    input  logic [31:0] ch1_addr,
    input  logic [11:0] ch1_size,
    input  logic        ch1_done,
    output logic        ch1_pending,
    output logic        busy,
    output logic        start_err,
    input  logic        cplh_cr,
    input  logic [7:0]  cpld_cr,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data
);

    rd_state_e       state;
    logic [29:0]     addr_q;
    logic [9:0]      remaining_dw;
    logic [10:0]     chunk_dw;
    logic [2:0]      word_cnt;
    logic [CR_W-1:0] cplh_avail;
    logic [CR_W-1:0] cpld_avail;
    logic            accept;
    logic            debit;
    logic [2:0]      hdr_idx;
    logic [15:0]     hdr_next;
    logic [3:0]      last_be;
    logic            unused_bits;

    assign unused_bits = ^{ch1_addr[1:0], ch1_size[1:0]};

    assign accept = ch1_start && (state == StIdle) && !ch1_pending && (ch1_size[11:2] != 10'd0);
    assign debit  = (state == StHdr) && (word_cnt == 3'd0);
    assign busy   = (state != StIdle);

    dma_cr_meter #(
        .CPLH_INIT (CPLH_INIT),
        .CPLD_INIT (CPLD_INIT)
    ) u_cr_meter (
        .clk_125    (clk_125),
        .rst        (rst),
        .debit      (debit),
        .debit_dw   (chunk_dw),
        .ret_h      (cplh_cr),
        .ret_dw     (cpld_cr),
        .cplh_avail (cplh_avail),
        .cpld_avail (cpld_avail)
    );

    // Header word to present on the next cycle
    always_comb begin
        hdr_idx  = (state == StHdr) ? word_cnt + 3'd1 : 3'd0;
        last_be  = (chunk_dw == 11'd1) ? 4'h0 : 4'hF;
        hdr_next = 16'h0000;
        case (hdr_idx)
            3'd0:    hdr_next = {FMT_TYPE_MRD32, 8'h00};
            3'd1:    hdr_next = {6'b0, chunk_dw[9:0]};  // 1024 DW wraps to 0
            3'd2:    hdr_next = REQ_ID;
            3'd3:    hdr_next = {5'b0, CH1_TAG, last_be, 4'hF};
            3'd4:    hdr_next = addr_q[29:14];
            3'd5:    hdr_next = {addr_q[13:0], 2'b00};
            default: hdr_next = 16'h0000;
        endcase
    end

    // Request FSM with registered TX outputs
    always_ff @(posedge clk_125) begin
        if (rst) begin
            state        <= StIdle;
            addr_q       <= '0;
            remaining_dw <= '0;
            chunk_dw     <= '0;
            word_cnt     <= '0;
            ch1_pending  <= 1'b0;
            start_err    <= 1'b0;
            tx_req       <= 1'b0;
            tx_st        <= 1'b0;
            tx_end       <= 1'b0;
            tx_data      <= '0;
        end else begin
            start_err <= ch1_start && !accept;
            if (ch1_done && (state == StIdle)) begin
                ch1_pending <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (accept) begin
                        addr_q       <= ch1_addr[31:2];
                        remaining_dw <= ch1_size[11:2];
                        ch1_pending  <= 1'b1;
                        state        <= StCalc;
                    end
                end
                StCalc: begin
                    chunk_dw <= calc_chunk_dw(remaining_dw, addr_q[9:0], MAX_RD_BYTES);
                    state    <= StWaitCr;
                end
                StWaitCr: begin
                    if ((cplh_avail != '0) && (cpld_avail >= {1'b0, chunk_dw})) begin
                        tx_req <= 1'b1;
                        state  <= StReq;
                    end
                end
                StReq: begin
                    if (tx_rdy) begin
                        tx_req   <= 1'b0;
                        tx_st    <= 1'b1;
                        tx_data  <= hdr_next;
                        word_cnt <= 3'd0;
                        state    <= StHdr;
                    end
                end
                StHdr: begin
                    if (word_cnt == 3'(HDR_WORDS - 1)) begin
                        tx_end       <= 1'b0;
                        tx_data      <= '0;
                        addr_q       <= addr_q + 30'(chunk_dw);
                        remaining_dw <= remaining_dw - chunk_dw[9:0];
                        state        <= (remaining_dw == chunk_dw[9:0]) ? StIdle : StCalc;
                    end else begin
                        word_cnt <= word_cnt + 3'd1;
                        tx_st    <= 1'b0;
                        tx_end   <= (word_cnt == 3'(HDR_WORDS - 2));
                        tx_data  <= hdr_next;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_rd_req_tx.sv
// Directed bench for dma_rd_req_tx with default parameters.
module tb_dma_rd_req_tx;

    logic        clk_125 = 1'b0;
    logic        rst;
    logic        ch1_start;
    logic [31:0] ch1_addr;
    logic [11:0] ch1_size;
    logic        ch1_done;
    logic        ch1_pending;
    logic        busy;
    logic        start_err;
    logic        cplh_cr;
    logic [7:0]  cpld_cr;
    logic        tx_req;
    logic        tx_rdy;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] w [6];
    logic [15:0] t2_len  [3] = '{16'h0010, 16'h0080, 16'h0070};
    logic [15:0] t2_addr [3] = '{16'h0FC0, 16'h1000, 16'h1200};
    int          lat;

    always #4 clk_125 = ~clk_125;

    dma_rd_req_tx dut (
        .clk_125     (clk_125),
        .rst         (rst),
        .ch1_start   (ch1_start),
        .ch1_addr    (ch1_addr),
        .ch1_size    (ch1_size),
        .ch1_done    (ch1_done),
        .ch1_pending (ch1_pending),
        .busy        (busy),
        .start_err   (start_err),
        .cplh_cr     (cplh_cr),
        .cpld_cr     (cpld_cr),
        .tx_req      (tx_req),
        .tx_rdy      (tx_rdy),
        .tx_st       (tx_st),
        .tx_end      (tx_end),
        .tx_data     (tx_data)
    );

    task automatic step();
        @(posedge clk_125);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cr(input string tag, input logic [31:0] h, input logic [31:0] d);
        chk({tag, "_cplh"}, 32'(dut.u_cr_meter.cplh_avail), h);
        chk({tag, "_cpld"}, 32'(dut.u_cr_meter.cpld_avail), d);
    endtask

    task automatic start_job(input logic [31:0] a, input logic [11:0] s);
        ch1_addr  = a;
        ch1_size  = s;
        ch1_start = 1'b1;
        step();
        ch1_start = 1'b0;
    endtask

    task automatic ret_cr(input logic [7:0] dw);
        cplh_cr = 1'b1;
        cpld_cr = dw;
        step();
        cplh_cr = 1'b0;
        cpld_cr = 8'h00;
    endtask

    task automatic pulse_done();
        ch1_done = 1'b1;
        step();
        ch1_done = 1'b0;
    endtask

    task automatic wait_st(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (tx_st === 1'b1) break;
            step();
        end
        chk({tag, "_st_seen"}, 32'(tx_st), 32'd1);
    endtask

    // Call while word 0 is on the bus; leaves the bench in the w5 cycle
    task automatic read_tlp(input string tag);
        w[0] = tx_data;
        for (int k = 1; k < 6; k++) begin
            step();
            w[k] = tx_data;
        end
        chk({tag, "_end"}, 32'(tx_end), 32'd1);
    endtask

    initial begin
        rst = 1'b1; ch1_start = 1'b0; ch1_addr = '0; ch1_size = '0; ch1_done = 1'b0;
        cplh_cr = 1'b0; cpld_cr = '0; tx_rdy = 1'b1;
        step(); step();
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(ch1_pending), 0);
        chk("rst_start_err", 32'(start_err), 0);
        chk_cr("rst", 8, 128);
        rst = 1'b0;
        step();

        // 1: single 256-byte read
        start_job(32'h0000_1000, 12'd256);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_req_c1", 32'(tx_req), 0);
        step();
        chk("t1_req_c2", 32'(tx_req), 0);
        step();
        chk("t1_req_c3", 32'(tx_req), 1);
        wait_st("t1");
        read_tlp("t1");
        chk("t1_w0", 32'(w[0]), 32'h0000);
        chk("t1_w1", 32'(w[1]), 32'h0040);
        chk("t1_w2", 32'(w[2]), 32'h0000);
        chk("t1_w3", 32'(w[3]), 32'h01FF);
        chk("t1_w4", 32'(w[4]), 32'h0000);
        chk("t1_w5", 32'(w[5]), 32'h1000);
        chk_cr("t1_debit", 7, 64);
        step();
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_tx_end_low", 32'(tx_end), 0);
        chk("t1_pending", 32'(ch1_pending), 1);
        pulse_done();
        chk("t1_pending_clr", 32'(ch1_pending), 0);
        ret_cr(8'd64);
        chk_cr("t1_ret", 8, 128);

        // 2: 4 KB boundary split, credits returned after each TLP
        start_job(32'h0000_0FC0, 12'd1024);
        for (int t = 0; t < 3; t++) begin
            wait_st("t2");
            read_tlp("t2");
            chk("t2_len", 32'(w[1]), 32'(t2_len[t]));
            chk("t2_addr_hi", 32'(w[4]), 32'h0000);
            chk("t2_addr_lo", 32'(w[5]), 32'(t2_addr[t]));
            ret_cr(t2_len[t][7:0]);
            if (t == 0) begin
                pulse_done();
                chk("t2_done_ignored", 32'(ch1_pending), 1);
            end
        end
        chk("t2_busy_end", 32'(busy), 0);
        chk_cr("t2_ret", 8, 128);
        pulse_done();

        // 3: data-credit stall between chunks
        start_job(32'h0000_2000, 12'd1536);
        wait_st("t3a");
        read_tlp("t3a");
        ret_cr(8'd128);
        wait_st("t3b");
        read_tlp("t3b");
        chk("t3b_w5", 32'(w[5]), 32'h2200);
        for (int i = 0; i < 8; i++) step();
        chk("t3_stall_req", 32'(tx_req), 0);
        chk("t3_stall_busy", 32'(busy), 1);
        chk_cr("t3_stall", 7, 0);
        ret_cr(8'd128);
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            if (tx_req === 1'b1) break;
            step();
            lat++;
        end
        chk("t3_resume_le3", 32'(lat <= 3), 1);
        wait_st("t3c");
        read_tlp("t3c");
        chk("t3c_w5", 32'(w[5]), 32'h2400);
        ret_cr(8'd128);
        chk("t3_busy_end", 32'(busy), 0);
        chk_cr("t3_ret", 8, 128);
        pulse_done();

        // 4: single-DW read and rejected starts
        start_job(32'h0000_3000, 12'd4);
        wait_st("t4");
        read_tlp("t4");
        chk("t4_w1", 32'(w[1]), 32'h0001);
        chk("t4_w3", 32'(w[3]), 32'h010F);
        chk("t4_w5", 32'(w[5]), 32'h3000);
        step();
        ret_cr(8'd1);
        start_job(32'h0000_3100, 12'd64);
        chk("t4_err_pending", 32'(start_err), 1);
        step();
        chk("t4_err_pulse", 32'(start_err), 0);
        step(); step();
        chk("t4_no_req", 32'(tx_req), 0);
        chk("t4_no_busy", 32'(busy), 0);
        pulse_done();
        chk("t4_pending_clr", 32'(ch1_pending), 0);
        start_job(32'h0000_3100, 12'd3);
        chk("t4_err_size0", 32'(start_err), 1);
        chk("t4_size0_pending", 32'(ch1_pending), 0);

        // 5: return and debit in the same cycle, then saturation
        start_job(32'h0000_5000, 12'd256);
        wait_st("t5");
        cplh_cr = 1'b1;
        cpld_cr = 8'd64;
        step();
        cplh_cr = 1'b0;
        cpld_cr = 8'd0;
        chk_cr("t5_net", 8, 128);
        chk("t5_w1", 32'(tx_data), 32'h0040);
        for (int i = 0; i < 4; i++) step();
        chk("t5_end", 32'(tx_end), 1);
        step();
        ret_cr(8'd64);
        chk_cr("t5_sat", 8, 128);
        pulse_done();

        // 6: reset in the middle of a header
        start_job(32'h0000_6000, 12'd256);
        wait_st("t6");
        step(); step(); step();
        chk("t6_w3", 32'(tx_data), 32'h01FF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_tx_req", 32'(tx_req), 0);
        chk("t6_tx_st", 32'(tx_st), 0);
        chk("t6_tx_end", 32'(tx_end), 0);
        chk("t6_tx_data", 32'(tx_data), 0);
        chk("t6_pending", 32'(ch1_pending), 0);
        chk("t6_busy", 32'(busy), 0);
        chk_cr("t6_rst", 8, 128);
        step();
        chk("t6_no_resume", 32'(tx_st), 0);
        start_job(32'h0000_7000, 12'd8);
        wait_st("t6n");
        read_tlp("t6n");
        chk("t6n_w1", 32'(w[1]), 32'h0002);
        chk("t6n_w3", 32'(w[3]), 32'h01FF);
        chk("t6n_w5", 32'(w[5]), 32'h7000);
        step();
        chk("t6n_busy_end", 32'(busy), 0);
        chk_cr("t6n_debit", 7, 126);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
